// File: rtl/multi_port_queueing_domain.sv
// Multi-port queueing front end: per-queue round-robin arbitration into NUMBER_OF_QUEUES FIFOs with occupancy throttles.
// Optional build macro MPQD_THROTTLE_HYSTERESIS_EN selects hysteretic throttle release against queues_lower_threshold.
module multi_port_queueing_domain #(
  parameter int NUMBER_OF_PORTS  = 2,
  parameter int NUMBER_OF_QUEUES = 4,
  parameter int DATA_SIZE        = 678,
  parameter int QUEUE_LENGTH     = 16,
  parameter int REGISTER_SIZE    = 32
) (
  input  logic                                                          clock,
  input  logic                                                          reset,
  input  logic [NUMBER_OF_PORTS-1:0][DATA_SIZE-1:0]                     in_packets,
  input  logic [NUMBER_OF_PORTS-1:0]                                    in_valid,
  input  logic [NUMBER_OF_PORTS-1:0][$clog2(NUMBER_OF_QUEUES)-1:0]      in_qid,
  output logic [NUMBER_OF_PORTS-1:0]                                    in_ready,
  input  logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0]                queues_higher_threshold,
  input  logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0]                queues_lower_threshold,
  input  logic [$clog2(NUMBER_OF_QUEUES)-1:0]                           select_id,
  input  logic                                                          consume,
  output logic [NUMBER_OF_QUEUES-1:0][DATA_SIZE-1:0]                    queues_to_selector_packets,
  output logic [NUMBER_OF_QUEUES-1:0]                                   empty,
  output logic [NUMBER_OF_QUEUES-1:0]                                   full,
  output logic [NUMBER_OF_QUEUES-1:0]                                   lastElem,
  output logic [NUMBER_OF_QUEUES-1:0][$clog2(QUEUE_LENGTH+1)-1:0]       occupancy,
  output logic [NUMBER_OF_QUEUES-1:0]                                   kill_the_core,
  output logic                                                          consume_error
);

  localparam int QW = $clog2(NUMBER_OF_QUEUES);
  localparam int AW = $clog2(QUEUE_LENGTH);
  localparam int CW = $clog2(QUEUE_LENGTH + 1);
  localparam int PW = (NUMBER_OF_PORTS > 1) ? $clog2(NUMBER_OF_PORTS) : 1;

`ifdef MPQD_THROTTLE_HYSTERESIS_EN
  function automatic logic throttle_next(input logic cur,
                                         input logic [REGISTER_SIZE-1:0] occ,
                                         input logic [REGISTER_SIZE-1:0] hi,
                                         input logic [REGISTER_SIZE-1:0] lo);
    logic release_ok;
    if (hi == '0) return 1'b0;
    if (occ >= hi) return 1'b1;
    // A low level at or above the high level degenerates to release below the high level.
    release_ok = (lo >= hi) ? 1'b1 : (occ <= lo);
    return cur && !release_ok;
  endfunction
`else
  function automatic logic throttle_next(input logic [REGISTER_SIZE-1:0] occ,
                                         input logic [REGISTER_SIZE-1:0] hi);
    return (hi != '0) && (occ >= hi);
  endfunction

  logic unused_lower_threshold;
  assign unused_lower_threshold = ^queues_lower_threshold;
`endif

  logic [NUMBER_OF_QUEUES-1:0]          push;
  logic [NUMBER_OF_QUEUES-1:0]          pop;
  logic [NUMBER_OF_QUEUES-1:0][PW-1:0]  win;

  for (genvar q = 0; q < NUMBER_OF_QUEUES; q++) begin : g_q
    logic [NUMBER_OF_PORTS-1:0] req;
    logic                       found;
    logic [PW-1:0]              winner;
    logic [PW-1:0]              rr;
    logic [AW-1:0]              wr_ptr;
    logic [AW-1:0]              rd_ptr;
    logic [CW-1:0]              cnt_p1;
    logic [CW-1:0]              cnt_nxt;
    logic                       empty_p1;
    logic                       full_p1;
    logic                       last_p1;
    logic                       kill_p1;
    logic                       kill_nxt;
    logic [DATA_SIZE-1:0]       mem [QUEUE_LENGTH];

    // Round-robin search: ports at or above rr first, then wrap to the low ports.
    always_comb begin
      req    = '0;
      found  = 1'b0;
      winner = '0;
      for (int p = 0; p < NUMBER_OF_PORTS; p++) begin
        req[p] = in_valid[p] && (in_qid[p] == QW'(q));
      end
      for (int p = 0; p < NUMBER_OF_PORTS; p++) begin
        if (!found && req[p] && (PW'(p) >= rr)) begin
          found  = 1'b1;
          winner = PW'(p);
        end
      end
      for (int p = 0; p < NUMBER_OF_PORTS; p++) begin
        if (!found && req[p]) begin
          found  = 1'b1;
          winner = PW'(p);
        end
      end
    end

    assign push[q] = found && !full_p1 && !reset;
    assign win[q]  = winner;
    assign pop[q]  = consume && (select_id == QW'(q)) && !empty_p1;

    always_comb begin
      case ({push[q], pop[q]})
        2'b10:   cnt_nxt = cnt_p1 + CW'(1);
        2'b01:   cnt_nxt = cnt_p1 - CW'(1);
        default: cnt_nxt = cnt_p1;
      endcase
    end

`ifdef MPQD_THROTTLE_HYSTERESIS_EN
    assign kill_nxt = throttle_next(kill_p1, REGISTER_SIZE'(cnt_nxt),
                                    queues_higher_threshold[q], queues_lower_threshold[q]);
`else
    assign kill_nxt = throttle_next(REGISTER_SIZE'(cnt_nxt), queues_higher_threshold[q]);
`endif

    // Stage p1: pointers, count, status and throttle registered from next-state count.
    always_ff @(posedge clock) begin
      if (reset) begin
        rr       <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        cnt_p1   <= '0;
        empty_p1 <= 1'b1;
        full_p1  <= 1'b0;
        last_p1  <= 1'b0;
        kill_p1  <= 1'b0;
      end else begin
        if (push[q]) begin
          wr_ptr <= wr_ptr + AW'(1);
          rr     <= (winner == PW'(NUMBER_OF_PORTS - 1)) ? '0 : winner + PW'(1);
        end
        if (pop[q]) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        cnt_p1   <= cnt_nxt;
        empty_p1 <= (cnt_nxt == '0);
        full_p1  <= (cnt_nxt == CW'(QUEUE_LENGTH));
        last_p1  <= (cnt_nxt == CW'(1));
        kill_p1  <= kill_nxt;
      end
    end

    // Storage is data-only; stale entries stay hidden behind the reset pointers.
    always_ff @(posedge clock) begin
      if (push[q]) begin
        mem[wr_ptr] <= in_packets[winner];
      end
    end

    assign queues_to_selector_packets[q] = mem[rd_ptr];
    assign empty[q]         = empty_p1;
    assign full[q]          = full_p1;
    assign lastElem[q]      = last_p1;
    assign occupancy[q]     = cnt_p1;
    assign kill_the_core[q] = kill_p1;
  end

  always_comb begin
    in_ready = '0;
    for (int q = 0; q < NUMBER_OF_QUEUES; q++) begin
      for (int p = 0; p < NUMBER_OF_PORTS; p++) begin
        if (push[q] && (win[q] == PW'(p))) begin
          in_ready[p] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      consume_error <= 1'b0;
    end else begin
      consume_error <= consume && empty[select_id];
    end
  end

endmodule

// File: tb/tb_multi_port_queueing_domain.sv
// Directed self-checking bench for multi_port_queueing_domain with hand-computed expectations.
module tb_multi_port_queueing_domain;

  localparam int NP = 2;
  localparam int NQ = 4;
  localparam int DS = 678;
  localparam int QL = 16;
  localparam int RS = 32;
  localparam int CW = $clog2(QL + 1);

  logic                     clock = 1'b0;
  logic                     reset = 1'b1;
  logic [NP-1:0][DS-1:0]    in_packets;
  logic [NP-1:0]            in_valid;
  logic [NP-1:0][1:0]       in_qid;
  logic [NP-1:0]            in_ready;
  logic [NQ-1:0][RS-1:0]    hi_th;
  logic [NQ-1:0][RS-1:0]    lo_th;
  logic [1:0]               select_id;
  logic                     consume;
  logic [NQ-1:0][DS-1:0]    heads;
  logic [NQ-1:0]            empty;
  logic [NQ-1:0]            full;
  logic [NQ-1:0]            last_elem;
  logic [NQ-1:0][CW-1:0]    occupancy;
  logic [NQ-1:0]            kill;
  logic                     consume_error;

  int checks = 0;
  int errors = 0;
  logic expk;

  always #5 clock = ~clock;

  multi_port_queueing_domain #(
    .NUMBER_OF_PORTS(NP), .NUMBER_OF_QUEUES(NQ), .DATA_SIZE(DS),
    .QUEUE_LENGTH(QL), .REGISTER_SIZE(RS)
  ) dut (
    .clock(clock), .reset(reset),
    .in_packets(in_packets), .in_valid(in_valid), .in_qid(in_qid), .in_ready(in_ready),
    .queues_higher_threshold(hi_th), .queues_lower_threshold(lo_th),
    .select_id(select_id), .consume(consume),
    .queues_to_selector_packets(heads),
    .empty(empty), .full(full), .lastElem(last_elem), .occupancy(occupancy),
    .kill_the_core(kill), .consume_error(consume_error)
  );

  task automatic check(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DS-1:0] pk(input int port, input int n);
    logic [DS-1:0] v;
    v = '0;
    v[DS-1] = 1'b1;
    v[31:0] = port * 65536 + n;
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    in_valid = '0;
    consume  = 1'b0;
  endtask

  initial begin
    in_packets = '0; in_valid = '0; in_qid = '0;
    hi_th = '0; lo_th = '0; select_id = '0; consume = 1'b0;
    expk = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    in_valid = 2'b11;
    #1 check("ready_in_reset", 1024'(in_ready), 1024'(0));
    in_valid = '0;
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_empty", 1024'(empty), 1024'(4'hF));
    check("rst_full", 1024'(full), 1024'(0));
    check("rst_last", 1024'(last_elem), 1024'(0));
    check("rst_occ", 1024'(occupancy), 1024'(0));
    check("rst_kill", 1024'(kill), 1024'(0));
    check("rst_cerr", 1024'(consume_error), 1024'(0));

    // Collision fairness on queue 2
    for (int k = 0; k < 4; k++) begin
      in_valid = 2'b11; in_qid[0] = 2'd2; in_qid[1] = 2'd2;
      in_packets[0] = pk(0, k); in_packets[1] = pk(1, k);
      #1 check("coll_ready", 1024'(in_ready), (k % 2 == 0) ? 1024'(2'b01) : 1024'(2'b10));
      tick();
    end
    idle();
    check("coll_occ", 1024'(occupancy[2]), 1024'(4));
    for (int k = 0; k < 4; k++) begin
      check("coll_head", 1024'(heads[2]), 1024'(pk(k % 2, k)));
      consume = 1'b1; select_id = 2'd2;
      tick();
    end
    idle();
    check("coll_drained", 1024'(empty[2]), 1024'(1));

    // Full back-pressure on queue 0
    for (int k = 0; k < 16; k++) begin
      in_valid = 2'b01; in_qid[0] = 2'd0; in_packets[0] = pk(0, 100 + k);
      #1 check("fill_ready", 1024'(in_ready[0]), 1024'(1));
      tick();
    end
    idle();
    check("full_flag", 1024'(full[0]), 1024'(1));
    check("full_occ", 1024'(occupancy[0]), 1024'(16));
    in_valid = 2'b01; in_packets[0] = pk(0, 116); consume = 1'b1; select_id = 2'd0;
    #1 check("full_refuse", 1024'(in_ready[0]), 1024'(0));
    tick();
    consume = 1'b0;
    check("full_pop_occ", 1024'(occupancy[0]), 1024'(15));
    check("full_pop_flag", 1024'(full[0]), 1024'(0));
    check("full_pop_head", 1024'(heads[0]), 1024'(pk(0, 101)));
    #1 check("full_retry", 1024'(in_ready[0]), 1024'(1));
    tick();
    idle();
    check("full_again_occ", 1024'(occupancy[0]), 1024'(16));
    check("full_again_flag", 1024'(full[0]), 1024'(1));
    for (int k = 0; k < 16; k++) begin
      check("drain_head", 1024'(heads[0]), (k < 15) ? 1024'(pk(0, 101 + k)) : 1024'(pk(0, 116)));
      consume = 1'b1; select_id = 2'd0;
      tick();
    end
    idle();
    check("drain_empty", 1024'(empty[0]), 1024'(1));

    // Parallel pushes, then push+pop on queue 0
    in_valid = 2'b11; in_qid[0] = 2'd0; in_qid[1] = 2'd3;
    in_packets[0] = pk(0, 200); in_packets[1] = pk(1, 201);
    #1 check("par_ready", 1024'(in_ready), 1024'(2'b11));
    tick();
    idle();
    check("par_occ0", 1024'(occupancy[0]), 1024'(1));
    check("par_occ3", 1024'(occupancy[3]), 1024'(1));
    check("par_empty", 1024'(empty), 1024'(4'b0110));
    check("par_last", 1024'(last_elem), 1024'(4'b1001));
    in_valid = 2'b01; in_qid[0] = 2'd0; in_packets[0] = pk(0, 202);
    consume = 1'b1; select_id = 2'd0;
    #1 check("pp_ready", 1024'(in_ready), 1024'(2'b01));
    tick();
    idle();
    check("pp_occ0", 1024'(occupancy[0]), 1024'(1));
    check("pp_head0", 1024'(heads[0]), 1024'(pk(0, 202)));
    check("pp_head3", 1024'(heads[3]), 1024'(pk(1, 201)));
    check("pp_cerr", 1024'(consume_error), 1024'(0));
    consume = 1'b1; select_id = 2'd0; tick();
    select_id = 2'd3; tick();
    idle();
    check("pp_clean", 1024'(empty), 1024'(4'hF));

    // Empty pop on queue 1
    consume = 1'b1; select_id = 2'd1;
    tick();
    idle();
    check("epop_cerr", 1024'(consume_error), 1024'(1));
    check("epop_empty", 1024'(empty), 1024'(4'hF));
    check("epop_occ", 1024'(occupancy[1]), 1024'(0));
    tick();
    check("epop_pulse_end", 1024'(consume_error), 1024'(0));
    in_valid = 2'b10; in_qid[1] = 2'd1; in_packets[1] = pk(1, 300);
    consume = 1'b1; select_id = 2'd1;
    #1 check("epush_ready", 1024'(in_ready), 1024'(2'b10));
    tick();
    idle();
    check("epush_cerr", 1024'(consume_error), 1024'(1));
    check("epush_occ", 1024'(occupancy[1]), 1024'(1));
    check("epush_head", 1024'(heads[1]), 1024'(pk(1, 300)));
    consume = 1'b1; select_id = 2'd1;
    tick();
    idle();
    check("epush_pop_cerr", 1024'(consume_error), 1024'(0));
    check("epush_pop_empty", 1024'(empty[1]), 1024'(1));

    // Throttle high=8 low=3 on queue 0
    hi_th[0] = 32'd8; lo_th[0] = 32'd3;
    expk = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      in_valid = 2'b01; in_qid[0] = 2'd0; in_packets[0] = pk(0, 400 + k);
      tick();
      idle();
`ifdef MPQD_THROTTLE_HYSTERESIS_EN
      expk = (k >= 8) ? 1'b1 : ((k <= 3) ? 1'b0 : expk);
`else
      expk = (k >= 8);
`endif
      check("thr_fill_occ", 1024'(occupancy[0]), 1024'(k));
      check("thr_fill_kill", 1024'(kill[0]), 1024'(expk));
    end
    for (int k = 7; k >= 0; k--) begin
      consume = 1'b1; select_id = 2'd0;
      tick();
      idle();
`ifdef MPQD_THROTTLE_HYSTERESIS_EN
      expk = (k >= 8) ? 1'b1 : ((k <= 3) ? 1'b0 : expk);
`else
      expk = (k >= 8);
`endif
      check("thr_drain_occ", 1024'(occupancy[0]), 1024'(k));
      check("thr_drain_kill", 1024'(kill[0]), 1024'(expk));
    end
    hi_th = '0; lo_th = '0;

    // Reset while queue 1 holds 5 entries pushed by port 0
    for (int k = 0; k < 5; k++) begin
      in_valid = 2'b01; in_qid[0] = 2'd1; in_packets[0] = pk(0, 500 + k);
      tick();
    end
    idle();
    check("pre_rst_occ", 1024'(occupancy[1]), 1024'(5));
    reset = 1'b1;
    in_valid = 2'b11; in_qid[0] = 2'd1; in_qid[1] = 2'd1;
    in_packets[0] = pk(0, 600); in_packets[1] = pk(1, 601);
    #1 check("mid_rst_ready", 1024'(in_ready), 1024'(0));
    tick();
    reset = 1'b0;
    check("mrst_empty", 1024'(empty), 1024'(4'hF));
    check("mrst_occ", 1024'(occupancy), 1024'(0));
    check("mrst_full", 1024'(full), 1024'(0));
    check("mrst_last", 1024'(last_elem), 1024'(0));
    check("mrst_kill", 1024'(kill), 1024'(0));
    check("mrst_cerr", 1024'(consume_error), 1024'(0));
    #1 check("mrst_rr", 1024'(in_ready), 1024'(2'b01));
    tick();
    idle();
    check("mrst_new_occ", 1024'(occupancy[1]), 1024'(1));
    check("mrst_new_head", 1024'(heads[1]), 1024'(pk(0, 600)));
    consume = 1'b1; select_id = 2'd1;
    tick();
    idle();
    check("mrst_final_empty", 1024'(empty), 1024'(4'hF));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
